controller: RTL and testbench
=============================

// Module: controller
// PURPOSE
//  - Test-stimulus sequencer at the head of the two-master bus system.
//  - On a start request it decodes a 5-bit scenario index into one command per bus master:
//    enable pulse, read/write flag, write data and 14-bit address.
//  - It then holds those commands until the external requests are withdrawn.
// PARAMETERS
//  - none (all constants live in controller_pkg)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   synchronous, active-high; one clock, no other clock domains
//  start       in   1   launch request; edge-detected internally, may be held several cycles
//  m1_request  in   1   master 1 participates in the scenario; must stay high for its duration
//  m2_request  in   1   master 2 participates in the scenario; same rule as m1_request
//  state_in    in   5   scenario index 0..31
//  m1_enable   out  1   one-cycle command strobe to master 1
//  m2_enable   out  1   one-cycle command strobe to master 2
//  m1_read_en  out  1   master 1 direction: 1 = read, 0 = write
//  m2_read_en  out  1   master 2 direction: 1 = read, 0 = write
//  data_in1    out  8   master 1 write data
//  data_in2    out  8   master 2 write data
//  addr_in1    out  14  master 1 address: [13:12] slave select, [11:0] offset
//  addr_in2    out  14  master 2 address: same layout as addr_in1
// BEHAVIOUR
//  - Reset: FSM = IDLE; every output 0; start_d = 0. Same result when asserted mid-operation.
//  - start_d registers start each cycle. launch = start & ~start_d & (m1_request | m2_request).
//  - Decode, s = state_in sampled at the launch edge:
//      addr1 = {s[3:2], 7'd0, s}
//      addr2 = {s[4] ? s[3:2] : ~s[3:2], 7'd0, s}
//        s[4]=1: both masters hit the same slave (contention case)
//      data1 = {3'b0,s} ^ 8'hA5;  data2 = {3'b0,s} ^ 8'h5A
//      rd1 = s[0];  rd2 = s[1]
//  - FSM states:
//      IDLE: on launch, register decoded fields for each master whose request is high
//            (zeros for a non-participant), set mX_enable = mX_request, go to ISSUE.
//            Outputs are visible one cycle after the launch edge.
//      ISSUE: exactly one cycle; enables return to 0; go to HOLD.
//      HOLD: addr/data/read_en held stable; on the first edge with
//            m1_request==0 && m2_request==0, clear all outputs and go to IDLE.
//  - start edges outside IDLE are ignored; no queuing.
//  - A start held high does not relaunch.
//  - A start rise with both requests low: no launch, stay IDLE.
//  - Requests dropping during ISSUE: ISSUE still completes, then HOLD exits on the next edge.
//  - A request rising during HOLD has no effect on the outputs.
//  - Back-to-back scenarios need start to be sampled low at least once between launches.
//  - Single-bit logic only; no arithmetic overflow concerns.
// STRUCTURE
//  - controller_pkg: FSM state enum (IDLE, ISSUE, HOLD); constants DATA1_KEY=8'hA5,
//    DATA2_KEY=8'h5A; struct cmd_t {rd, data[7:0], addr[13:0]}.
//  - Sub-module controller_scenario_decode: combinational state_in -> two cmd_t.
//  - Top holds the FSM, the start edge detector and the output registers.
// TESTING
//  - reset=1 for 2 cycles with random inputs -> all outputs 0, FSM IDLE.
//  - m1_request=1, m2_request=0, state_in=1, start high 2 cycles
//    -> one m1_enable pulse; addr_in1=14'h0001, data_in1=8'hA4, m1_read_en=1;
//       m2_enable never set and all master-2 outputs 0.
//  - Requests dropped after ~22 cycles -> outputs cleared the following cycle.
//    Then state_in=5, m1 only -> addr_in1=14'h1005, data_in1=8'hA0, m1_read_en=1.
//  - state_in=8, both requests set -> addr_in1=14'h2008, data_in1=8'hAD, m1_read_en=0;
//    addr_in2=14'h1008, data_in2=8'h52, m2_read_en=0; both enables pulse in the same cycle.
//  - state_in=20 (s[4]=1), both requests -> addr_in1[13:12] == addr_in2[13:12] == 2'b01.
//  - Second start during HOLD -> ignored.
//  - start with both requests 0 -> no enable.
//  - reset during HOLD -> outputs 0 next cycle.

Source files
------------

// File: rtl/controller_pkg.sv
// controller_pkg: shared FSM states, data keys and command record for the scenario controller
package controller_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    localparam logic [7:0] DATA1_KEY = 8'hA5;
    localparam logic [7:0] DATA2_KEY = 8'h5A;
    typedef struct packed {
        logic        rd;
        logic [7:0]  data;
        logic [13:0] addr;
    } cmd_t;
endpackage

// File: rtl/controller_scenario_decode.sv
// controller_scenario_decode: maps a 5-bit scenario index to one command per bus master
// Ports: state_in (scenario index) -> cmd1, cmd2 (rd flag, write data, address per master)
module controller_scenario_decode
    import controller_pkg::*;
(
    input  logic [4:0] state_in,
    output cmd_t       cmd1,
    output cmd_t       cmd2
);
    // s[4] set: master 2 targets the same slave as master 1 to create contention
    assign cmd1 = '{rd: state_in[0], data: {3'b0, state_in} ^ DATA1_KEY,
                    addr: {state_in[3:2], 7'd0, state_in}};
    assign cmd2 = '{rd: state_in[1], data: {3'b0, state_in} ^ DATA2_KEY,
                    addr: {state_in[4] ? state_in[3:2] : ~state_in[3:2], 7'd0, state_in}};
endmodule

// File: rtl/controller.sv
// controller: test-stimulus sequencer issuing one command per bus master on a start edge
// Ports: clk, reset (sync, active-high); start, m1_request, m2_request, state_in in;
//        mX_enable (one-cycle strobe), mX_read_en, data_inX, addr_inX out per master
module controller
    import controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        m1_request,
    input  logic        m2_request,
    input  logic [4:0]  state_in,
    output logic        m1_enable,
    output logic        m2_enable,
    output logic        m1_read_en,
    output logic        m2_read_en,
    output logic [7:0]  data_in1,
    output logic [7:0]  data_in2,
    output logic [13:0] addr_in1,
    output logic [13:0] addr_in2
);
    state_t state, state_n;
    cmd_t   dec1, dec2, c1, c2, c1_n, c2_n;
    logic   start_d, en1, en2, en1_n, en2_n, launch;

    controller_scenario_decode u_decode (.state_in(state_in), .cmd1(dec1), .cmd2(dec2));

    // rising edge of start only, and only if some master participates
    assign launch = start & ~start_d & (m1_request | m2_request);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            start_d <= 1'b0;
            c1      <= '0;
            c2      <= '0;
            en1     <= 1'b0;
            en2     <= 1'b0;
        end else begin
            state   <= state_n;
            start_d <= start;
            c1      <= c1_n;
            c2      <= c2_n;
            en1     <= en1_n;
            en2     <= en2_n;
        end
    end

    always_comb begin
        state_n = state;
        c1_n    = c1;
        c2_n    = c2;
        en1_n   = 1'b0;
        en2_n   = 1'b0;
        case (state)
            IDLE: if (launch) begin
                state_n = ISSUE;
                c1_n    = m1_request ? dec1 : '0;
                c2_n    = m2_request ? dec2 : '0;
                en1_n   = m1_request;
                en2_n   = m2_request;
            end
            ISSUE: state_n = HOLD;
            HOLD: if (!m1_request && !m2_request) begin
                state_n = IDLE;
                c1_n    = '0;
                c2_n    = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign m1_enable  = en1;
    assign m2_enable  = en2;
    assign m1_read_en = c1.rd;
    assign m2_read_en = c2.rd;
    assign data_in1   = c1.data;
    assign data_in2   = c2.data;
    assign addr_in1   = c1.addr;
    assign addr_in2   = c2.addr;
endmodule

// File: tb/tb_controller.sv
// tb_controller: directed self-checking bench for the scenario controller
module tb_controller;
    logic        clk = 1'b0;
    logic        reset, start, m1_request, m2_request;
    logic [4:0]  state_in;
    logic        m1_enable, m2_enable, m1_read_en, m2_read_en;
    logic [7:0]  data_in1, data_in2;
    logic [13:0] addr_in1, addr_in2;
    logic [47:0] outs;
    int          checks = 0;
    int          errors = 0;
    int          pulses;

    controller dut (
        .clk(clk), .reset(reset), .start(start),
        .m1_request(m1_request), .m2_request(m2_request), .state_in(state_in),
        .m1_enable(m1_enable), .m2_enable(m2_enable),
        .m1_read_en(m1_read_en), .m2_read_en(m2_read_en),
        .data_in1(data_in1), .data_in2(data_in2),
        .addr_in1(addr_in1), .addr_in2(addr_in2)
    );

    always #5 clk = ~clk;

    assign outs = {m1_enable, m2_enable, m1_read_en, m2_read_en, data_in1, data_in2, addr_in1, addr_in2};

    function automatic logic [47:0] pk(input logic e1, input logic e2, input logic r1, input logic r2,
                                       input logic [7:0] d1, input logic [7:0] d2,
                                       input logic [13:0] a1, input logic [13:0] a2);
        return {e1, e2, r1, r2, d1, d2, a1, a2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; m1_request = 1'b0; m2_request = 1'b0; state_in = 5'd0;
        for (int i = 0; i < 2; i++) begin
            start      = 1'($urandom);
            m1_request = 1'($urandom);
            m2_request = 1'($urandom);
            state_in   = 5'($urandom);
            tick();
        end
        chk("reset", outs, '0);
        reset = 1'b0; start = 1'b0; m1_request = 1'b0; m2_request = 1'b0;
        tick();
        chk("idle", outs, '0);

        // m1 only, scenario 1, start held two cycles
        m1_request = 1'b1; state_in = 5'd1; start = 1'b1;
        tick();
        chk("s1_launch", outs, pk(1, 0, 1, 0, 8'hA4, 8'h00, 14'h0001, 14'h0000));
        pulses = 0;
        tick();
        chk("s1_issue_done", outs, pk(0, 0, 1, 0, 8'hA4, 8'h00, 14'h0001, 14'h0000));
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(m1_enable) + int'(m2_enable);
        end
        chk("s1_no_repulse", 48'(pulses), 48'd0);
        chk("s1_hold", outs, pk(0, 0, 1, 0, 8'hA4, 8'h00, 14'h0001, 14'h0000));
        m1_request = 1'b0;
        tick();
        chk("s1_clear", outs, '0);

        // m1 only, scenario 5; second start and m2 rise during HOLD are ignored
        m1_request = 1'b1; state_in = 5'd5; start = 1'b1;
        tick();
        chk("s5_launch", outs, pk(1, 0, 1, 0, 8'hA0, 8'h00, 14'h1005, 14'h0000));
        start = 1'b0;
        tick();
        tick();
        chk("s5_hold", outs, pk(0, 0, 1, 0, 8'hA0, 8'h00, 14'h1005, 14'h0000));
        start = 1'b1; state_in = 5'd8; m2_request = 1'b1;
        tick();
        chk("s5_restart_ignored", outs, pk(0, 0, 1, 0, 8'hA0, 8'h00, 14'h1005, 14'h0000));
        start = 1'b0; m1_request = 1'b0; m2_request = 1'b0;
        tick();
        chk("s5_clear", outs, '0);

        // both masters, scenario 8; requests drop during ISSUE
        m1_request = 1'b1; m2_request = 1'b1; state_in = 5'd8; start = 1'b1;
        tick();
        chk("s8_launch", outs, pk(1, 1, 0, 0, 8'hAD, 8'h52, 14'h2008, 14'h1008));
        start = 1'b0; m1_request = 1'b0; m2_request = 1'b0;
        tick();
        chk("s8_issue_completes", outs, pk(0, 0, 0, 0, 8'hAD, 8'h52, 14'h2008, 14'h1008));
        tick();
        chk("s8_clear", outs, '0);

        // contention scenario 20; start kept high across the return to IDLE
        m1_request = 1'b1; m2_request = 1'b1; state_in = 5'd20; start = 1'b1;
        tick();
        chk("s20_launch", outs, pk(1, 1, 0, 0, 8'hB1, 8'h4E, 14'h1014, 14'h1014));
        chk("s20_same_slave", 48'({addr_in1[13:12], addr_in2[13:12]}), 48'b0101);
        tick();
        m1_request = 1'b0; m2_request = 1'b0;
        tick();
        chk("s20_clear", outs, '0);
        m1_request = 1'b1; m2_request = 1'b1;
        tick();
        chk("held_start_no_launch", outs, '0);

        // start edge with no requests
        start = 1'b0; m1_request = 1'b0; m2_request = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("no_req_no_launch", outs, '0);
        start = 1'b0;
        tick();

        // reset during HOLD
        m1_request = 1'b1; state_in = 5'd3; start = 1'b1;
        tick();
        chk("s3_launch", outs, pk(1, 0, 1, 0, 8'hA6, 8'h00, 14'h0003, 14'h0000));
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("reset_in_hold", outs, '0);
        reset = 1'b0; m1_request = 1'b0;
        tick();
        chk("after_reset_idle", outs, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
